axi_lite_slave_mem: RTL and testbench
=====================================

// Module: axi_lite_slave_mem
// PURPOSE
//  AXI4-Lite slave endpoint: byte-lane memory of BUFFER_SIZE words serving one transaction at a time.
//  Sits directly downstream of the master/driver; consumes axi_lite_bus_t traffic (AR/R/AW/W/B).
//  Provides the DUT memory that the scoreboard mirrors.
// PARAMETERS
//  ADDR_WIDTH   32     address bus width
//  DATA_WIDTH   8      data bus width; multiple of 8
//  STRB_WIDTH   DATA_WIDTH/8  derived, not overridable
//  BUFFER_SIZE  4096   memory depth in DATA_WIDTH words; power of 2; index = addr[$clog2(BUFFER_SIZE)-1:0]
// PORTS
//  ACLK     in   1           clock, rising edge
//  ARESETN  in   1           asynchronous active-low reset
//  araddr   in   ADDR_WIDTH  read address
//  arvalid  in   1           read address valid
//  arready  out  1           read address accept
//  rdata    out  DATA_WIDTH  read data
//  rresp    out  2           read response
//  rvalid   out  1           read data valid
//  rready   in   1           master ready for read data
//  awaddr   in   ADDR_WIDTH  write address
//  awvalid  in   1           write address valid
//  awready  out  1           write address accept
//  wdata    in   DATA_WIDTH  write data
//  wstrb    in   STRB_WIDTH  byte-lane strobes
//  wvalid   in   1           write data valid
//  wready   out  1           write data accept
//  bresp    out  2           write response
//  bvalid   out  1           write response valid
//  bready   in   1           master ready for response
// BEHAVIOUR
//  Reset (async on ARESETN low): state=IDLE, last_grant=READ; all ready/valid outputs 0; rdata=0; rresp=bresp=00.
//   Memory array not reset; contents survive reset, including reset mid-transaction.
//  FSM states (state_type): IDLE, RADDR, RDATA, WADDR, WDATA, WRESP. All outputs registered.
//  IDLE: all readies 0.
//   awvalid only -> WADDR. arvalid only -> RADDR.
//   Both asserted -> grant the type opposite last_grant; first after reset = write. Update last_grant on grant.
//  WADDR: awready=1 for exactly one cycle (awvalid held by master); latch awaddr -> WDATA.
//  WDATA: wready=1 until wvalid. On wvalid&wready, write each lane i with wstrb[i]=1; wstrb=0 -> no write, OKAY.
//   Then -> WRESP.
//  WRESP: bvalid=1, bresp held stable until bready; on bvalid&bready -> IDLE. No new AR/AW accepted meanwhile.
//  RADDR: arready=1 for exactly one cycle; latch araddr -> RDATA.
//  RDATA: rvalid=1; rdata=mem[idx] captured on entry, held stable until rready; on rvalid&rready -> IDLE.
//  Latency: arvalid seen in IDLE cycle N -> arready cycle N+1 -> rvalid cycle N+2.
//   Write: awready N+1, wready from N+2, bvalid the cycle after the W handshake.
//  Read-after-write to the same address returns the new data.
//  Master dropping valid before ready is a protocol violation; behaviour undefined, not checked here.
//  Responses: OKAY (00) always, except the out-of-range case below. EXOKAY/SLVERR never generated.
// CONFIGURATION
//  AXI_SLV_DECERR_EN undefined: addr >= BUFFER_SIZE aliases via low index bits; resp OKAY.
//  AXI_SLV_DECERR_EN defined: addr >= BUFFER_SIZE -> write suppressed, bresp=11.
//   Read returns rdata=0, rresp=11. Handshake timing unchanged.
// TESTING
//  1. Write 0x4 <- 0xA5, wstrb=1; then read 0x4 -> bresp=00; rvalid at N+2, rdata=0xA5, rresp=00.
//  2. Write 0x14 <- 0x3C, wstrb=0 after 0x14 holds 0x11 -> bresp=00; readback 0x11.
//  3. arvalid+awvalid same cycle after reset (aw 0x4 <- 0x5A, ar 0x4) -> write served first.
//     Read then returns 0x5A; next simultaneous pair grants read first.
//  4. bready held low 5 cycles, new arvalid pending -> bvalid/bresp stable 5 cycles, arready stays 0.
//     IDLE one cycle after bready.
//  5. Write 0x1004 <- 0x77: macro off -> 0x4 reads 0x77, OKAY.
//     Macro on -> bresp=11, read 0x1004 rresp=11 rdata=0, 0x4 unchanged.
//  6. ARESETN low during RDATA (rready=0) -> rvalid=0 immediately, state IDLE.
//     Re-read of the same address returns the pre-reset value.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-lane memory, one transaction in flight at a time.
// Optional AXI_SLV_DECERR_EN: out-of-range addresses return DECERR instead of aliasing.
module axi_lite_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BUFFER_SIZE = 4096,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int unsigned IDX_W = $clog2(BUFFER_SIZE);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_type;

  state_type             state;
  logic                  last_grant_write;
  logic [IDX_W-1:0]      widx;
  logic                  wr_err;
  logic                  ar_oor;
  logic                  aw_oor;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

`ifdef AXI_SLV_DECERR_EN
  assign ar_oor = |araddr[ADDR_WIDTH-1:IDX_W];
  assign aw_oor = |awaddr[ADDR_WIDTH-1:IDX_W];
`else
  // Upper address bits are ignored: accesses alias onto the low index bits.
  logic unused_addr;
  assign unused_addr = ^{araddr[ADDR_WIDTH-1:IDX_W], awaddr[ADDR_WIDTH-1:IDX_W]};
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  assign mem_we = (state == WDATA) && wvalid && wready && !wr_err;

  // Memory contents are deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state            <= IDLE;
      last_grant_write <= 1'b0;
      widx             <= '0;
      wr_err           <= 1'b0;
      arready          <= 1'b0;
      rvalid           <= 1'b0;
      rdata            <= '0;
      rresp            <= 2'b00;
      awready          <= 1'b0;
      wready           <= 1'b0;
      bvalid           <= 1'b0;
      bresp            <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          // Contested grants alternate; uncontested grants leave the history alone.
          if (awvalid && arvalid) begin
            if (last_grant_write) begin
              state            <= RADDR;
              arready          <= 1'b1;
              last_grant_write <= 1'b0;
            end else begin
              state            <= WADDR;
              awready          <= 1'b1;
              last_grant_write <= 1'b1;
            end
          end else if (awvalid) begin
            state   <= WADDR;
            awready <= 1'b1;
          end else if (arvalid) begin
            state   <= RADDR;
            arready <= 1'b1;
          end
        end
        WADDR: begin
          awready <= 1'b0;
          widx    <= awaddr[IDX_W-1:0];
          wr_err  <= aw_oor;
          wready  <= 1'b1;
          state   <= WDATA;
        end
        WDATA: begin
          if (wvalid && wready) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= wr_err ? 2'b11 : 2'b00;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid && bready) begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            state  <= IDLE;
          end
        end
        RADDR: begin
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rdata   <= ar_oor ? '0 : mem[araddr[IDX_W-1:0]];
          rresp   <= ar_oor ? 2'b11 : 2'b00;
          state   <= RDATA;
        end
        RDATA: begin
          if (rvalid && rready) begin
            rvalid <= 1'b0;
            rresp  <= 2'b00;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Scoreboard bench for axi_lite_slave_mem: drivers push expected responses, a negedge
// monitor pops and compares them on every R/B handshake.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [7:0]  wdata = '0;
  logic [0:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_r [$];
  logic [1:0] exp_b [$];
  logic [9:0] r_e;
  logic [1:0] b_e;

`ifdef AXI_SLV_DECERR_EN
  localparam logic [1:0] OorResp = 2'b11;
`else
  localparam logic [1:0] OorResp = 2'b00;
`endif

  axi_lite_slave_mem dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as expected", name);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return awready;
      1:       return wready;
      2:       return bvalid;
      3:       return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name, output int n);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!sig(w) && n < 50);
    if (!sig(w)) fail(name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: each R or B handshake consumes one scoreboard entry.
  always @(negedge ACLK) begin
    if (ARESETN && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        fail("unexpected_r");
      end else begin
        r_e = exp_r.pop_front();
        chk("rdata", 32'(rdata), 32'(r_e[7:0]));
        chk("rresp", 32'(rresp), 32'(r_e[9:8]));
      end
    end
    if (ARESETN && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        fail("unexpected_b");
      end else begin
        b_e = exp_b.pop_front();
        chk("bresp", 32'(bresp), 32'(b_e));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] data, input logic strb,
                           input logic [1:0] resp, input int bhold, input bit lat);
    int n;
    exp_b.push_back(resp);
    awaddr  = addr;
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = 1'b1;
    bready  = (bhold == 0);
    wait_sig(0, "awready_timeout", n);
    if (lat) chk("aw_latency", n, 2);
    tick();
    awvalid = 1'b0;
    wait_sig(1, "wready_timeout", n);
    if (lat) chk("w_latency", n, 1);
    tick();
    wvalid = 1'b0;
    wait_sig(2, "bvalid_timeout", n);
    if (lat) chk("b_latency", n, 1);
    for (int i = 0; i < bhold; i++) begin
      if (i > 0) @(negedge ACLK);
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("bresp_hold", 32'(bresp), 32'(resp));
      chk("arready_blocked", 32'(arready), 0);
    end
    if (bhold > 0) begin
      tick();
      bready = 1'b1;
      @(negedge ACLK);
    end
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] data, input logic [1:0] resp,
                          input bit lat);
    int n;
    exp_r.push_back({resp, data});
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    wait_sig(3, "arready_timeout", n);
    if (lat) chk("ar_latency", n, 2);
    tick();
    arvalid = 1'b0;
    wait_sig(4, "rvalid_timeout", n);
    if (lat) chk("r_latency", n, 1);
    tick();
    rready = 1'b1;
    @(negedge ACLK);
    tick();
    rready = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    tick();
    ARESETN = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge ACLK);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_bresp", 32'(bresp), 0);
    tick();
    ARESETN = 1'b1;
    tick();

    // Basic write/read with latency checks.
    axi_write(32'h4, 8'hA5, 1'b1, 2'b00, 0, 1'b1);
    axi_read(32'h4, 8'hA5, 2'b00, 1'b1);

    // Zero strobe leaves the old byte in place.
    axi_write(32'h14, 8'h11, 1'b1, 2'b00, 0, 1'b0);
    axi_write(32'h14, 8'h3C, 1'b0, 2'b00, 0, 1'b0);
    axi_read(32'h14, 8'h11, 2'b00, 1'b0);
    axi_write(32'hFFF, 8'hC3, 1'b1, 2'b00, 0, 1'b0);
    axi_write(32'h0, 8'h01, 1'b1, 2'b00, 0, 1'b0);
    axi_read(32'hFFF, 8'hC3, 2'b00, 1'b0);
    axi_read(32'h0, 8'h01, 2'b00, 1'b0);

    // Simultaneous requests after reset: write first, then read first.
    do_reset();
    fork
      axi_write(32'h4, 8'h5A, 1'b1, 2'b00, 0, 1'b0);
      axi_read(32'h4, 8'h5A, 2'b00, 1'b0);
    join
    fork
      axi_write(32'h4, 8'h66, 1'b1, 2'b00, 0, 1'b0);
      axi_read(32'h4, 8'h5A, 2'b00, 1'b0);
    join
    axi_read(32'h4, 8'h66, 2'b00, 1'b0);

    // Backpressured B with a read pending behind it.
    fork
      begin
        axi_write(32'h8, 8'h42, 1'b1, 2'b00, 5, 1'b0);
        @(negedge ACLK);
        chk("idle_after_b", 32'(arready), 0);
        @(negedge ACLK);
        chk("ar_after_idle", 32'(arready), 1);
      end
      begin
        wait_sig(2, "bvalid_seen_timeout", n);
        axi_read(32'h8, 8'h42, 2'b00, 1'b0);
      end
    join

    // Out-of-range write/read.
    axi_write(32'h1004, 8'h77, 1'b1, OorResp, 0, 1'b0);
`ifdef AXI_SLV_DECERR_EN
    axi_read(32'h1004, 8'h00, 2'b11, 1'b0);
    axi_read(32'h4, 8'h66, 2'b00, 1'b0);
`else
    axi_read(32'h4, 8'h77, 2'b00, 1'b0);
`endif

    // Reset while read data is stalled.
    araddr  = 32'h4;
    arvalid = 1'b1;
    wait_sig(3, "mid_arready_timeout", n);
    tick();
    arvalid = 1'b0;
    wait_sig(4, "mid_rvalid_timeout", n);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_arready", 32'(arready), 0);
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
`ifdef AXI_SLV_DECERR_EN
    axi_read(32'h4, 8'h66, 2'b00, 1'b0);
`else
    axi_read(32'h4, 8'h77, 2'b00, 1'b0);
`endif

    repeat (3) tick();
    chk("r_queue_empty", exp_r.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
